seq_detector: RTL and testbench

SEQ_DETECTOR -- requirements
Module: seq_detector

---
 rtl/seq_detector.sv | 93 +++++++++
 tb/tb_seq_detector.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detector.sv
// Serial pattern detector: zero-latency Mealy match against a loadable PAT_W-bit
// pattern, with overlap control, a registered match copy and a saturating count.
module seq_detector #(
    parameter int               PAT_W    = 3,
    parameter logic [PAT_W-1:0] PAT_INIT = 3'b010,
    parameter int               CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             clr,
    output logic             match,
    output logic             match_q,
    output logic [CNT_W-1:0] match_cnt
);
    localparam int                FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [PAT_W-1:0]  pattern_r;
    logic [PAT_W-2:0]  history_r;
    logic [FILL_W-1:0] fill_r;
    logic [CNT_W-1:0]  match_cnt_r;
    logic              match_q_r;

    logic              accept_s;
    logic              full_s;
    logic              match_s;
    logic [PAT_W-1:0]  window_s;

    // Oldest history bit lines up with pattern[PAT_W-1], current din with pattern[0].
    assign accept_s = din_valid & ~pat_load;
    assign full_s   = (fill_r == FILL_MAX);
    assign window_s = {history_r, din};

    // Mealy match decision for the current cycle
    always_comb begin
        if (accept_s && full_s && (window_s == pattern_r)) begin
            match_s = 1'b1;
        end else begin
            match_s = 1'b0;
        end
    end

    // Pattern, history and fill tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_r <= PAT_INIT;
            history_r <= {(PAT_W-1){1'b0}};
            fill_r    <= {FILL_W{1'b0}};
        end else if (pat_load) begin
            pattern_r <= pat_in;
            fill_r    <= {FILL_W{1'b0}};
        end else if (accept_s) begin
            history_r <= window_s[PAT_W-2:0];
            // A non-overlapping match consumes its bits, so refilling starts over.
            if (match_s && !overlap) begin
                fill_r <= {FILL_W{1'b0}};
            end else if (!full_s) begin
                fill_r <= fill_r + FILL_W'(1);
            end
        end
    end

    // Saturating match counter; clr wins over a coincident match
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            match_cnt_r <= {CNT_W{1'b0}};
        end else if (match_s && (match_cnt_r != CNT_MAX)) begin
            match_cnt_r <= match_cnt_r + CNT_W'(1);
        end
    end

    // One-cycle delayed copy of match
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q_r <= 1'b0;
        end else begin
            match_q_r <= match_s;
        end
    end

    assign match     = match_s;
    assign match_q   = match_q_r;
    assign match_cnt = match_cnt_r;

endmodule

// File: tb/tb_seq_detector.sv
// Scoreboard bench for seq_detector: a sliding-window reference model feeds expected
// results into a queue that a free-running monitor pops and compares every cycle.
module tb_seq_detector;
    localparam int          PAT_W    = 3;
    localparam logic [2:0]  PAT_INIT = 3'b010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       overlap = 1'b0;
    logic       pat_load = 1'b0;
    logic [2:0] pat_in = 3'b000;
    logic       clr = 1'b0;

    logic       match8, mq8, match2, mq2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    always #5 clk = ~clk;

    seq_detector u_dut8 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .clr(clr),
        .match(match8), .match_q(mq8), .match_cnt(cnt8)
    );

    seq_detector #(.PAT_W(3), .PAT_INIT(3'b010), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .clr(clr),
        .match(match2), .match_q(mq2), .match_cnt(cnt2)
    );

    typedef struct {
        int   id;
        logic m;
        logic mq;
        int   c8;
        int   c2;
    } exp_t;

    exp_t scb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   issued   = 0;
    int   retired  = 0;

    // Reference model: accepted bits since the last restart, newest at the back
    int         bitq[$];
    logic [2:0] mpat = PAT_INIT;
    int         mc8  = 0;
    int         mc2  = 0;

    task automatic chk(input string name, input int id, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, id, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic d, input logic ov,
                        input logic pl, input logic [2:0] pi, input logic c);
        exp_t e;
        int   w;
        @(negedge clk);
        rst = r; din_valid = v; din = d; overlap = ov; pat_load = pl; pat_in = pi; clr = c;
        e.m = 1'b0;
        if (r) begin
            bitq.delete();
            mpat = PAT_INIT;
            mc8  = 0;
            mc2  = 0;
        end else begin
            if (pl) begin
                mpat = pi;
                bitq.delete();
            end else if (v) begin
                if (bitq.size() == PAT_W - 1) begin
                    w = 0;
                    foreach (bitq[i]) w = (w << 1) | bitq[i];
                    w = ((w << 1) | int'(d)) & 7;
                    e.m = (w == int'(mpat));
                end
                if (e.m && !ov) begin
                    bitq.delete();
                end else begin
                    bitq.push_back(int'(d));
                    if (bitq.size() > PAT_W - 1) void'(bitq.pop_front());
                end
            end
            if (c) begin
                mc8 = 0;
                mc2 = 0;
            end else if (e.m) begin
                mc8 = (mc8 == 255) ? 255 : mc8 + 1;
                mc2 = (mc2 == 3) ? 3 : mc2 + 1;
            end
        end
        e.mq = e.m;
        e.c8 = mc8;
        e.c2 = mc2;
        e.id = issued;
        issued++;
        scb.push_back(e);
    endtask

    task automatic bitin(input logic d, input logic ov);
        step(1'b0, 1'b1, d, ov, 1'b0, 3'b000, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    endtask

    // Monitor: match checked mid-cycle, registered outputs just after the edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (scb.size() > 0) begin
                e = scb.pop_front();
                chk("match8", e.id, int'(match8), int'(e.m));
                chk("match2", e.id, int'(match2), int'(e.m));
                @(posedge clk);
                #1;
                chk("match_q8", e.id, int'(mq8), int'(e.mq));
                chk("match_q2", e.id, int'(mq2), int'(e.mq));
                chk("match_cnt8", e.id, int'(cnt8), e.c8);
                chk("match_cnt2", e.id, int'(cnt2), e.c2);
                retired++;
            end
        end
    end

    initial begin
        int guard;
        // Overlapping 0,1,0,1,0: matches on bits 3 and 5
        do_reset();
        bitin(1'b0, 1'b1); bitin(1'b1, 1'b1); bitin(1'b0, 1'b1);
        bitin(1'b1, 1'b1); bitin(1'b0, 1'b1);
        // Non-overlapping: match on bit 3 only
        do_reset();
        bitin(1'b0, 1'b0); bitin(1'b1, 1'b0); bitin(1'b0, 1'b0);
        bitin(1'b1, 1'b0); bitin(1'b0, 1'b0);
        // Gap of invalid cycles inside a match
        do_reset();
        bitin(1'b0, 1'b1); bitin(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, i[0], 1'b1, 1'b0, 3'b000, 1'b0);
        bitin(1'b0, 1'b1);
        // Pattern reload restarts detection
        do_reset();
        bitin(1'b1, 1'b1); bitin(1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'b110, 1'b0);
        bitin(1'b0, 1'b1);
        bitin(1'b1, 1'b1); bitin(1'b1, 1'b1); bitin(1'b0, 1'b1);
        // Five matches saturate the 2-bit counter, then clr meets a match
        do_reset();
        bitin(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            bitin(1'b1, 1'b1);
            bitin(1'b0, 1'b1);
        end
        bitin(1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1);
        // Mid-stream reset discards partial history
        do_reset();
        bitin(1'b0, 1'b1); bitin(1'b1, 1'b1);
        do_reset();
        bitin(1'b0, 1'b1);
        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < 75),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) < 3),
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 99) < 3));
        end
        guard = 0;
        while (retired != issued && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #3;
        if (retired != issued) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: retired %0d expected %0d", retired, issued);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
